// File: rtl/if_id_fetch_ctrl_if.sv
// Fetch/decode bundle: instruction-memory handshake, EX redirect and hazard inputs, IF/ID decode outputs.
// master = fetch controller side, slave = memory/pipeline side.
interface if_id_fetch_ctrl_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        memreadE;
  logic [4:0]  RdE;
  logic [31:0] instrD;
  logic [31:0] pcD;
  logic        validD;
  logic        bubbleE;

  modport master (
    output imem_req, imem_addr, instrD, pcD, validD, bubbleE,
    input  imem_ack, imem_rdata, redirect_valid, redirect_pc, memreadE, RdE
  );

  modport slave (
    input  imem_req, imem_addr, instrD, pcD, validD, bubbleE,
    output imem_ack, imem_rdata, redirect_valid, redirect_pc, memreadE, RdE
  );
endinterface

// File: rtl/if_id_fetch_ctrl.sv
// IF/ID sequencer: one outstanding imem request feeding a DEPTH-entry FIFO, ack->validD in 2 cycles; fetch idles when full, decode holds on load-use.
// Optional IF_ID_PERF_EN adds load-use and redirect cycle counters.
module if_id_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic               clk,
  input  logic               rst,
  if_id_fetch_ctrl_if.master bus
`ifdef IF_ID_PERF_EN
  ,
  output logic [31:0]        load_use_cnt,
  output logic [31:0]        redirect_cnt
`endif
);
  localparam int          AW   = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  localparam logic [31:0] NOP  = 32'h0000_0013;

  typedef enum logic [1:0] {IDLE = 2'd0, FETCH = 2'd1, FLUSH = 2'd2} state_t;

  state_t        r_state, w_next_state;
  logic [31:0]   r_pcF, r_flush_addr, r_instrD, r_pcD;
  logic          r_validD;
  logic [31:0]   r_fifo_pc  [DEPTH];
  logic [31:0]   r_fifo_ins [DEPTH];
  logic [AW-1:0] r_wptr, r_rptr;
  logic [AW:0]   r_count, w_count_nxt;
  logic          w_haz, w_push, w_pop;

  assign w_haz = bus.memreadE && (bus.RdE != 5'd0) && r_validD &&
                 ((r_instrD[19:15] == bus.RdE) || (r_instrD[24:20] == bus.RdE));
  assign w_push = (r_state == FETCH) && bus.imem_ack && !bus.redirect_valid;
  assign w_pop  = !bus.redirect_valid && !w_haz && (r_count != '0);
  assign w_count_nxt = r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);

  always_ff @(posedge clk) begin
    if (rst) r_state <= FETCH;
    else     r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    if (bus.redirect_valid) begin
      // An unanswered request must be drained before the new target can be fetched
      if ((r_state != IDLE) && !bus.imem_ack) w_next_state = FLUSH;
      else                                    w_next_state = FETCH;
    end else begin
      case (r_state)
        IDLE:    if (r_count < FULL) w_next_state = FETCH;
        FETCH:   if (bus.imem_ack && !(w_count_nxt < FULL)) w_next_state = IDLE;
        FLUSH:   if (bus.imem_ack) w_next_state = FETCH;
        default: w_next_state = FETCH;
      endcase
    end
  end

  always_comb begin
    bus.imem_req  = (r_state != IDLE);
    bus.imem_addr = (r_state == FLUSH) ? r_flush_addr : r_pcF;
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_pc[r_wptr]  <= r_pcF;
      r_fifo_ins[r_wptr] <= bus.imem_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pcF        <= RESET_PC;
      r_flush_addr <= RESET_PC;
      r_wptr       <= '0;
      r_rptr       <= '0;
      r_count      <= '0;
      r_instrD     <= NOP;
      r_pcD        <= 32'h0;
      r_validD     <= 1'b0;
    end else if (bus.redirect_valid) begin
      r_pcF    <= bus.redirect_pc & ~32'h3;
      r_wptr   <= '0;
      r_rptr   <= '0;
      r_count  <= '0;
      r_instrD <= NOP;
      r_validD <= 1'b0;
      if (r_state == FETCH) r_flush_addr <= r_pcF;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + AW'(1);
        r_pcF  <= r_pcF + 32'd4;
      end
      if (w_pop) begin
        r_rptr   <= r_rptr + AW'(1);
        r_instrD <= r_fifo_ins[r_rptr];
        r_pcD    <= r_fifo_pc[r_rptr];
        r_validD <= 1'b1;
      end else if (!w_haz) begin
        r_instrD <= NOP;
        r_validD <= 1'b0;
      end
      r_count <= w_count_nxt;
    end
  end

  assign bus.instrD  = r_instrD;
  assign bus.pcD     = r_pcD;
  assign bus.validD  = r_validD;
  assign bus.bubbleE = w_haz && !bus.redirect_valid && !rst;

`ifdef IF_ID_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      load_use_cnt <= 32'h0;
      redirect_cnt <= 32'h0;
    end else begin
      if (bus.bubbleE)        load_use_cnt <= load_use_cnt + 32'd1;
      if (bus.redirect_valid) redirect_cnt <= redirect_cnt + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_if_id_fetch_ctrl.sv
// Bench for if_id_fetch_ctrl: latency-programmable memory returning addr as data, scoreboard on decode output,
// hazard vector table and hand-written stall/redirect sequences.
module tb_if_id_fetch_ctrl;
  logic clk;
  logic rst;
  if_id_fetch_ctrl_if bus();
`ifdef IF_ID_PERF_EN
  logic [31:0] load_use_cnt, redirect_cnt;
`endif

  if_id_fetch_ctrl #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef IF_ID_PERF_EN
    ,
    .load_use_cnt (load_use_cnt),
    .redirect_cnt (redirect_cnt)
`endif
  );

  localparam logic [31:0] NOP      = 32'h0000_0013;
  localparam logic [31:0] CONSUMER = 32'h0012_8313;  // addi x6, x5, 1

  int checks = 0;
  int errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: acks after lat wait cycles, data = mem[addr]
  logic [31:0] mem [0:255];
  int lat  = 0;
  int mcnt = 0;
  assign bus.imem_ack   = bus.imem_req && (mcnt == lat);
  assign bus.imem_rdata = mem[bus.imem_addr[9:2]];
  always @(posedge clk) begin
    if (rst)                                mcnt <= 0;
    else if (!bus.imem_req || bus.imem_ack) mcnt <= 0;
    else                                    mcnt <= mcnt + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard of expected decode outputs
  typedef struct { logic [31:0] pc; logic [31:0] ins; } sb_t;
  sb_t exp_q[$];
  logic mon_en = 1'b0;
  always @(negedge clk) begin
    if (mon_en && bus.validD) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected: got pcD %h with empty queue", bus.pcD);
      end else begin
        sb_t e;
        e = exp_q.pop_front();
        chk("sb_pcD", bus.pcD, e.pc);
        chk("sb_instrD", bus.instrD, e.ins);
      end
    end
  end

  task automatic push_exp(input logic [31:0] pc, input logic [31:0] ins);
    sb_t e;
    e.pc  = pc;
    e.ins = ins;
    exp_q.push_back(e);
  endtask

  task automatic mon_off();
    @(posedge clk);
    #1 mon_en = 1'b0;
    @(negedge clk);
  endtask

  // Returns at the negedge inside cycle 0 (first cycle with rst low)
  task automatic do_reset(input int l);
    rst = 1'b1;
    lat = l;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'h0;
    bus.memreadE       = 1'b0;
    bus.RdE            = 5'd0;
    exp_q.delete();
    for (int i = 0; i < 256; i++) mem[i] = 32'(i * 4);
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  typedef struct { logic mr; logic [4:0] rd; logic [31:0] ins; logic bub; } hz_vec_t;
  hz_vec_t hv [6];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'h0;
    bus.memreadE       = 1'b0;
    bus.RdE            = 5'd0;

    hv[0] = '{1'b1, 5'd5, CONSUMER,     1'b1};  // rs1 match
    hv[1] = '{1'b1, 5'd0, CONSUMER,     1'b0};  // x0 never hazards
    hv[2] = '{1'b0, 5'd5, CONSUMER,     1'b0};  // not a load
    hv[3] = '{1'b1, 5'd1, CONSUMER,     1'b1};  // imm bits alias rs2 field
    hv[4] = '{1'b1, 5'd7, CONSUMER,     1'b0};  // unrelated register
    hv[5] = '{1'b1, 5'd9, 32'h0090_01B3, 1'b1}; // add x3, x0, x9: rs2 match

    // Zero-wait streaming with reset state
    do_reset(0);
    chk("rst_validD", 32'(bus.validD), 32'd0);
    chk("rst_instrD", bus.instrD, NOP);
    chk("rst_pcD", bus.pcD, 32'h0);
    chk("rst_imem_addr", bus.imem_addr, 32'h0);
    chk("rst_imem_req", 32'(bus.imem_req), 32'd1);
    chk("rst_bubbleE", 32'(bus.bubbleE), 32'd0);
    for (int k = 0; k < 19; k++) push_exp(32'(4 * k), 32'(4 * k));
    mon_en = 1'b1;
    for (int c = 0; c < 20; c++) begin
      chk("t1_imem_addr", bus.imem_addr, 32'(4 * c));
      chk("t1_validD", 32'(bus.validD), (c >= 2) ? 32'd1 : 32'd0);
      @(negedge clk);
    end
    mon_off();
    chk("t1_drain", 32'(exp_q.size()), 32'd0);

    // Three wait states: one word every four cycles
    do_reset(3);
    for (int k = 0; k < 5; k++) push_exp(32'(4 * k), 32'(4 * k));
    mon_en = 1'b1;
    for (int c = 0; c < 24; c++) begin
      chk("t2_imem_addr", bus.imem_addr, 32'(4 * (c / 4)));
      chk("t2_imem_req", 32'(bus.imem_req), 32'd1);
      chk("t2_validD", 32'(bus.validD), (c >= 5 && ((c - 5) % 4) == 0) ? 32'd1 : 32'd0);
      @(negedge clk);
    end
    mon_off();
    chk("t2_drain", 32'(exp_q.size()), 32'd0);

    // Hazard table: word at PC 0 reaches decode in cycle 2
    for (int v = 0; v < 6; v++) begin
      do_reset(0);
      mem[0] = hv[v].ins;
      repeat (2) @(negedge clk);
      bus.memreadE = hv[v].mr;
      bus.RdE      = hv[v].rd;
      #1;
      chk("hz_instrD", bus.instrD, hv[v].ins);
      chk("hz_bubbleE", 32'(bus.bubbleE), 32'(hv[v].bub));
      bus.memreadE = 1'b0;
      bus.RdE      = 5'd0;
    end

    // Single load-use bubble holds decode for one cycle
    do_reset(0);
    mem[1] = CONSUMER;
    repeat (3) @(negedge clk);
    bus.memreadE = 1'b1;
    bus.RdE      = 5'd5;
    #1;
    chk("t4_bubble_on", 32'(bus.bubbleE), 32'd1);
    chk("t4_pcD_c3", bus.pcD, 32'h4);
    @(negedge clk);
    chk("t4_pcD_held", bus.pcD, 32'h4);
    chk("t4_instrD_held", bus.instrD, CONSUMER);
    bus.memreadE = 1'b0;
    #1;
    chk("t4_bubble_off", 32'(bus.bubbleE), 32'd0);
    @(negedge clk);
    chk("t4_pcD_adv", bus.pcD, 32'h8);
`ifdef IF_ID_PERF_EN
    chk("t4_load_use_cnt", load_use_cnt, 32'd1);
`endif

    // Repeated hazard: FIFO fills to DEPTH, fetch idles, then resumes
    do_reset(0);
    mem[0] = CONSUMER;
    bus.memreadE = 1'b1;
    bus.RdE      = 5'd5;
    repeat (2) @(negedge clk);
    for (int c = 2; c < 8; c++) begin
      chk("t6_bubble", 32'(bus.bubbleE), 32'd1);
      chk("t6_pcD", bus.pcD, 32'h0);
      if (c >= 3) chk("t6_req_idle", 32'(bus.imem_req), 32'd0);
      @(negedge clk);
    end
    bus.memreadE = 1'b0;
    #1;
    chk("t6_release", 32'(bus.bubbleE), 32'd0);
    @(negedge clk);
    chk("t6_pcD_c9", bus.pcD, 32'h4);
    @(negedge clk);
    chk("t6_pcD_c10", bus.pcD, 32'h8);
    chk("t6_req_resume", 32'(bus.imem_req), 32'd1);
    chk("t6_addr_resume", bus.imem_addr, 32'hC);
    @(negedge clk);
    chk("t6_validD_c11", 32'(bus.validD), 32'd0);
    @(negedge clk);
    chk("t6_pcD_c12", bus.pcD, 32'hC);

    // Redirect while a request is outstanding: FLUSH eats the late ack
    do_reset(3);
    push_exp(32'h100, 32'h100);
    mon_en = 1'b1;
    @(negedge clk);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h0000_0103;
    @(negedge clk);
    bus.redirect_valid = 1'b0;
    chk("t5_flush_req", 32'(bus.imem_req), 32'd1);
    chk("t5_flush_addr_c2", bus.imem_addr, 32'h0);
    @(negedge clk);
    chk("t5_flush_addr_c3", bus.imem_addr, 32'h0);
    for (int c = 4; c < 11; c++) begin
      @(negedge clk);
      if (c <= 7) chk("t5_new_addr", bus.imem_addr, 32'h100);
      if (c <= 8) chk("t5_validD_low", 32'(bus.validD), 32'd0);
    end
    mon_off();
    chk("t5_drain", 32'(exp_q.size()), 32'd0);
`ifdef IF_ID_PERF_EN
    chk("t5_redirect_cnt", redirect_cnt, 32'd1);
`endif

    // Redirect coinciding with ack and a hazard
    do_reset(0);
    mem[0] = CONSUMER;
    repeat (2) @(negedge clk);
    bus.memreadE       = 1'b1;
    bus.RdE            = 5'd5;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h0000_0200;
    #1;
    chk("t7_bubble_masked", 32'(bus.bubbleE), 32'd0);
    @(negedge clk);
    bus.redirect_valid = 1'b0;
    bus.memreadE       = 1'b0;
    chk("t7_validD", 32'(bus.validD), 32'd0);
    chk("t7_instrD_nop", bus.instrD, NOP);
    chk("t7_addr", bus.imem_addr, 32'h200);
    chk("t7_req", 32'(bus.imem_req), 32'd1);
    push_exp(32'h200, 32'h200);
    push_exp(32'h204, 32'h204);
    mon_en = 1'b1;
    @(negedge clk);
    chk("t7_fifo_empty", 32'(bus.validD), 32'd0);
    repeat (2) @(negedge clk);
    mon_off();
    chk("t7_drain", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
